// File: rtl/exu_pkg.sv
// -----------------------------------------------------------------------------
// exu_pkg
// Shared definitions for the integer execution units of the multi-issue back
// end: ALU op encodings, the default payload widths and the stage payload
// record. Also provides small helpers that decode the op.
//
// Contents:
//   EXU_*            default widths/latency used by the execution units
//   OP_ENC_*         raw 2-bit op encodings as driven by the issue stage
//   alu_op_e         enumerated view of the same encodings
//   exu_payload_t    {valid, Pw, tag, result, exp} at the default widths
//   op_is_sub()      1 for SUB/SUBU
//   op_traps()       1 for the signed ops (ADD/SUB) that may raise overflow
//
// The optional saturation build (macro ADD_UNIT_PIPE_SAT_EN) does not change
// anything in this package.
// -----------------------------------------------------------------------------
package exu_pkg;

    localparam int EXU_DATA_W = 16;
    localparam int EXU_PREG_W = 5;
    localparam int EXU_TAG_W  = 4;
    localparam int EXU_LAT    = 2;

    localparam logic [1:0] OP_ENC_ADD  = 2'b00;
    localparam logic [1:0] OP_ENC_SUB  = 2'b01;
    localparam logic [1:0] OP_ENC_ADDU = 2'b10;
    localparam logic [1:0] OP_ENC_SUBU = 2'b11;

    typedef enum logic [1:0] {
        OP_ADD  = OP_ENC_ADD,
        OP_SUB  = OP_ENC_SUB,
        OP_ADDU = OP_ENC_ADDU,
        OP_SUBU = OP_ENC_SUBU
    } alu_op_e;

    typedef struct packed {
        logic                  valid;
        logic [EXU_PREG_W-1:0] Pw;
        logic [EXU_TAG_W-1:0]  tag;
        logic [EXU_DATA_W-1:0] result;
        logic                  exp;
    } exu_payload_t;

    // Bit 0 of the encoding selects subtraction.
    function automatic logic op_is_sub(input alu_op_e op);
        logic [1:0] enc;
        enc = op;
        return enc[0];
    endfunction

    // Bit 1 of the encoding marks the unsigned (never trapping) variants.
    function automatic logic op_traps(input alu_op_e op);
        logic [1:0] enc;
        enc = op;
        return ~enc[1];
    endfunction

endpackage : exu_pkg

// File: rtl/add_unit_pipe_if.sv
// -----------------------------------------------------------------------------
// add_unit_pipe_if
// Issue-side and writeback-side signal bundle of the pipelined add/sub unit.
//
// Signals:
//   flush, freeze_back        pipeline control from the back end
//   valid_add, op_add, Pw_add, busA_add, busB_add, tag_ROB_add
//                             issued op
//   valid_Result_add, Pw_Result_add, Result_add, exp_add, tag_ROB_Result_add
//                             result towards writeback / ROB
//   inflight_add              number of valid ops inside the unit
//
// Modports:
//   master  issue/writeback side (drives the op and control, reads results)
//   slave   the execution unit
//
// Identical in both builds of macro ADD_UNIT_PIPE_SAT_EN.
// -----------------------------------------------------------------------------
interface add_unit_pipe_if #(
    parameter int DATA_W = 16,
    parameter int PREG_W = 5,
    parameter int TAG_W  = 4,
    parameter int LAT    = 2
);
    localparam int CNT_W = $clog2(LAT + 1);

    logic              flush;
    logic              freeze_back;
    logic              valid_add;
    logic [1:0]        op_add;
    logic [PREG_W-1:0] Pw_add;
    logic [DATA_W-1:0] busA_add;
    logic [DATA_W-1:0] busB_add;
    logic [TAG_W-1:0]  tag_ROB_add;

    logic              valid_Result_add;
    logic [PREG_W-1:0] Pw_Result_add;
    logic [DATA_W-1:0] Result_add;
    logic              exp_add;
    logic [TAG_W-1:0]  tag_ROB_Result_add;
    logic [CNT_W-1:0]  inflight_add;

    modport master (
        output flush, freeze_back, valid_add, op_add, Pw_add,
               busA_add, busB_add, tag_ROB_add,
        input  valid_Result_add, Pw_Result_add, Result_add, exp_add,
               tag_ROB_Result_add, inflight_add
    );

    modport slave (
        input  flush, freeze_back, valid_add, op_add, Pw_add,
               busA_add, busB_add, tag_ROB_add,
        output valid_Result_add, Pw_Result_add, Result_add, exp_add,
               tag_ROB_Result_add, inflight_add
    );

endinterface : add_unit_pipe_if

// File: rtl/add_unit_core.sv
// -----------------------------------------------------------------------------
// add_unit_core
// Purely combinational add/sub datapath: result and signed-overflow flag.
//
// Ports:
//   i_a, i_b   operands (DATA_W)
//   i_op       alu_op_e: ADD/SUB trap on signed overflow, ADDU/SUBU never trap
//   o_result   A+B or A+~B+1, modulo 2^DATA_W
//   o_exp      signed overflow exception (ADD/SUB only)
//
// Build option ADD_UNIT_PIPE_SAT_EN: signed ops clamp to the most positive /
// most negative value on overflow and o_exp stays 0. Unsigned ops still wrap.
// -----------------------------------------------------------------------------
module add_unit_core
    import exu_pkg::*;
#(
    parameter int DATA_W = EXU_DATA_W
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_e           i_op,
    output logic [DATA_W-1:0] o_result,
    output logic              o_exp
);

    localparam int MSB = DATA_W - 1;

    logic              w_sub;
    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W-1:0] w_sum;
    logic              w_ovf;
    logic              w_trap;

    assign w_sub   = op_is_sub(i_op);
    // Subtraction is A + ~B + 1, so the carry-in is the subtract flag.
    assign w_b_eff = w_sub ? ~i_b : i_b;
    assign w_sum   = i_a + w_b_eff + {{(DATA_W-1){1'b0}}, w_sub};

    // Overflow when the effective addends agree in sign and the sum does not.
    // For SUB this is exactly "A and B differ in sign, result differs from A".
    assign w_ovf  = (i_a[MSB] == w_b_eff[MSB]) && (w_sum[MSB] != i_a[MSB]);
    assign w_trap = w_ovf && op_traps(i_op);

    always_comb begin
        o_result = w_sum;
        o_exp    = 1'b0;
`ifdef ADD_UNIT_PIPE_SAT_EN
        // A positive A can only overflow upwards, a negative A only downwards.
        if (w_trap) begin
            o_result = i_a[MSB] ? {1'b1, {(DATA_W-1){1'b0}}}
                                : {1'b0, {(DATA_W-1){1'b1}}};
        end
`else
        o_exp = w_trap;
`endif
    end

endmodule : add_unit_core

// File: rtl/add_unit_pipe.sv
// -----------------------------------------------------------------------------
// add_unit_pipe
// Pipelined integer add/sub execution unit. One op accepted per cycle, result
// delivered to writeback/ROB exactly LAT edges after acceptance.
//
// Parameters: DATA_W (>=2), PREG_W, TAG_W, LAT (1..4).
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset; clears all stage state
//   bus   add_unit_pipe_if.slave: issue inputs, flush/freeze_back control,
//         result outputs and inflight_add occupancy
//
// Pipeline: stages S1..S_LAT, arithmetic computed on the inputs and captured
// into S1, later stages only delay. Outputs come straight from S_LAT.
// Priority per edge: flush (clear all valid bits) > freeze_back (hold all)
// > advance (shift by one, S1 takes the issued op or a bubble).
//
// Build option ADD_UNIT_PIPE_SAT_EN selects saturating signed arithmetic in
// add_unit_core; this module and its ports are identical in both builds.
// -----------------------------------------------------------------------------
module add_unit_pipe
    import exu_pkg::*;
#(
    parameter int DATA_W = EXU_DATA_W,
    parameter int PREG_W = EXU_PREG_W,
    parameter int TAG_W  = EXU_TAG_W,
    parameter int LAT    = EXU_LAT
) (
    input logic             clk,
    input logic             rst,
    add_unit_pipe_if.slave  bus
);

    localparam int CNT_W = $clog2(LAT + 1);

    // Same field order as exu_payload_t, sized by this instance's parameters.
    typedef struct packed {
        logic              valid;
        logic [PREG_W-1:0] pw;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] result;
        logic              exp;
    } stage_t;

    stage_t            r_stage      [LAT];
    stage_t            w_stage_next [LAT];
    stage_t            w_head;
    logic [DATA_W-1:0] w_result;
    logic              w_exp;
    logic [CNT_W-1:0]  w_inflight;

    add_unit_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .i_a      (bus.busA_add),
        .i_b      (bus.busB_add),
        .i_op     (alu_op_e'(bus.op_add)),
        .o_result (w_result),
        .o_exp    (w_exp)
    );

    // S1 candidate. A bubble keeps the old payload so idle cycles do not
    // toggle the wide data flops; only the valid bit changes.
    always_comb begin
        w_head       = r_stage[0];
        w_head.valid = 1'b0;
        if (bus.valid_add) begin
            w_head.valid  = 1'b1;
            w_head.pw     = bus.Pw_add;
            w_head.tag    = bus.tag_ROB_add;
            w_head.result = w_result;
            w_head.exp    = w_exp;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign w_stage_next[gi] = w_head;
            end else begin : g_delay
                assign w_stage_next[gi] = r_stage[gi-1];
            end
        end
    endgenerate

    // Flush beats freeze: a squash must take effect even while the back end
    // is stalled, and an op issued alongside the flush is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) begin
                r_stage[i] <= '0;
            end
        end else if (bus.flush) begin
            for (int i = 0; i < LAT; i++) begin
                r_stage[i].valid <= 1'b0;
            end
        end else if (!bus.freeze_back) begin
            for (int i = 0; i < LAT; i++) begin
                r_stage[i] <= w_stage_next[i];
            end
        end
    end

    // Occupancy is a popcount of the stage valid flops, so it has no path
    // from the inputs and is zero right after reset or flush.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + CNT_W'(r_stage[i].valid);
        end
    end

    assign bus.valid_Result_add   = r_stage[LAT-1].valid;
    assign bus.Pw_Result_add      = r_stage[LAT-1].pw;
    assign bus.tag_ROB_Result_add = r_stage[LAT-1].tag;
    assign bus.Result_add         = r_stage[LAT-1].result;
    assign bus.exp_add            = r_stage[LAT-1].exp;
    assign bus.inflight_add       = w_inflight;

endmodule : add_unit_pipe

// File: doc/add_unit_pipe.md
Name: add_unit_pipe

Overview:
- Parametrised, pipelined integer add/sub execution unit for the multi-issue back end; successor to the single-cycle 16-bit adder.
- Takes one issued op per cycle from the issue stage.
- Delivers result, destination physical register, ROB tag and overflow exception to writeback/ROB after LAT cycles.
- Supports flush (squash all in-flight ops), freeze_back (hold the whole pipe) and an in-flight occupancy count for the issue scheduler.

Parameters:
- DATA_W, 16, operand/result width (>=2)
- PREG_W, 5, physical register index width
- TAG_W, 4, ROB tag width
- LAT, 2, pipeline latency in cycles from accept to result valid (1..4)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  squash all in-flight ops
- freeze_back  in  1  hold all pipeline state
- valid_add  in  1  issue valid
- op_add  in  2  00 ADD (signed, traps), 01 SUB (signed, traps), 10 ADDU, 11 SUBU (never trap)
- Pw_add  in  PREG_W  destination physical register
- busA_add  in  DATA_W  operand A
- busB_add  in  DATA_W  operand B
- tag_ROB_add  in  TAG_W  ROB tag
- valid_Result_add  out  1  result valid
- Pw_Result_add  out  PREG_W  destination of result
- Result_add  out  DATA_W  result
- exp_add  out  1  signed overflow exception
- tag_ROB_Result_add  out  TAG_W  ROB tag of result
- inflight_add  out  $clog2(LAT+1)  number of valid ops in the pipe

Behaviour:
- Reset:
  - rst low asynchronously clears every stage valid bit, data, Pw, tag and exp to 0.
  - All outputs read 0 while rst is low and until the first accepted op reaches the output.
- Structure:
  - LAT register stages S1..S_LAT; outputs driven directly from S_LAT; no combinational input-to-output path.
  - Arithmetic is evaluated combinationally on the inputs and captured into S1; S2..S_LAT only delay.
- Accept: an op is captured into S1 on an edge where valid_add=1, freeze_back=0, flush=0. Latency is exactly LAT edges from accept to valid_Result_add=1.
- Arithmetic:
  - ADD/ADDU: A+B mod 2^DATA_W.
  - SUB/SUBU: A+~B+1 mod 2^DATA_W.
  - exp=1 only for ADD/SUB on signed overflow (operand sign bits equal for ADD, different for SUB, and result sign differs from A's sign).
  - The result is still written when exp=1.
- Freeze: while freeze_back=1 and flush=0, all stages and outputs hold; inputs are ignored; issue must re-present the op. Output valid stays asserted for the whole freeze, and the consumer samples once.
- Advance: with freeze_back=0, every stage shifts by one each edge. If valid_add=0, S1 loads valid=0 (data don't-care, held at previous value to save toggles).
- Flush:
  - Highest priority. The next edge clears all valid bits, including S_LAT, so the output drops the cycle after flush.
  - An op presented in the same cycle is dropped.
  - Flush during freeze still clears.
- inflight_add: popcount of stage valid bits, registered-equivalent (derived from stage valid flops); 0 after reset or flush; max LAT.
- LAT=1: S1 is the output stage; behaviour as above with single-cycle latency.

Optional Feature:
- Macro ADD_UNIT_PIPE_SAT_EN.
- When defined:
  - ADD/SUB saturate on signed overflow (positive overflow gives 0111..1, negative gives 1000..0) and exp_add is forced 0.
  - ADDU/SUBU unchanged (wrap, no trap).
- When undefined: wrapping result with exp_add as above.
- Ports are identical in both builds.

Decomposition:
- Shared package exu_pkg:
  - alu_op_e enum (OP_ADD, OP_SUB, OP_ADDU, OP_SUBU)
  - exu_payload_t packed struct {valid, Pw, tag, result, exp}, parametrised through package localparams matching the defaults
  - op encoding constants
- One sub-module: add_unit_core, combinational A/B/op to result/exp including the saturation logic.
- add_unit_pipe owns only the stage registers, flush/freeze control and inflight counting.

Test Plan (DATA_W=16, LAT=2):
- Reset then ADD A=0x0003 B=0x0004 Pw=5 tag=2 -> 2 edges later: valid=1, Result=0x0007, Pw=5, tag=2, exp=0; valid=0 the following cycle.
- ADD 0x7FFF+0x0001 -> Result=0x8000, exp=1. With ADD_UNIT_PIPE_SAT_EN: Result=0x7FFF, exp=0. ADDU same operands -> 0x8000, exp=0.
- SUB 0x8000-0x0001 -> Result=0x7FFF, exp=1. SUBU 0x0000-0x0001 -> 0xFFFF, exp=0.
- Back-to-back ops tags 1,2,3 with freeze_back=1 for 3 cycles after the second accept -> outputs stall holding the same tag, inflight stays 2; results emerge in order 1,2,3 with no loss or duplication.
- Two ops in flight, flush=1 together with a new valid_add -> next cycle inflight=0, valid_Result_add=0, and no result ever appears for any of the three ops.
- Assert rst low mid-stream with 2 ops in flight -> outputs and inflight go to 0 immediately (asynchronously); after release, first new op appears after exactly LAT edges.
